// File: rtl/fetch_unit.sv
// Multi-cycle RV32I fetch stage: one instruction in flight over an imem req/ack handshake,
// presenting instr/pc to decode and taking the next-PC decision back when decode consumes it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  input  logic        i_dec_rdy,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_instr_vld,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_misalign,
  output logic [31:0] o_insn_cnt
);

  typedef enum logic [1:0] {StFetch, StValid, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic [31:0] cnt_q;
  logic        misalign_q;

  logic        transfer;
  logic        consume;
  logic        bad_target;
  logic [31:0] next_pc;

  // Request is gated by reset so a pending fetch is abandoned in the reset cycle itself.
  assign o_imem_req  = (state_q == StFetch) && !i_rst;
  assign o_imem_addr = i_rst ? RESET_PC : pc_q;

  assign transfer   = o_imem_req && i_imem_ack;
  assign consume    = (state_q == StValid) && i_dec_rdy;
  // Bit 0 is dropped as JALR does; only bit 1 makes a target unreachable.
  assign bad_target = i_pc_sel && i_alu_data[1];
  assign next_pc    = i_pc_sel ? (i_alu_data & 32'hFFFF_FFFE) : (pc_out_q + 32'd4);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0013;
      pc_out_q   <= RESET_PC;
      cnt_q      <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (transfer) begin
            instr_q  <= i_imem_rdata;
            pc_out_q <= pc_q;
            state_q  <= StValid;
          end
        end
        StValid: begin
          if (consume) begin
            cnt_q <= cnt_q + 32'd1;
            if (bad_target) begin
              misalign_q <= 1'b1;
              state_q    <= StHalt;
            end else begin
              pc_q    <= next_pc;
              state_q <= StFetch;
            end
          end
        end
        StHalt: ;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign o_instr     = instr_q;
  assign o_pc        = pc_out_q;
  assign o_pc_four   = pc_out_q + 32'd4;
  assign o_instr_vld = (state_q == StValid);
  assign o_misalign  = misalign_q;
  assign o_insn_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a rule-level reference model checked every cycle,
// plus hand-computed literal checks along the test sequence.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, pc_sel, dec_rdy, imem_ack;
  logic [31:0] alu_data, imem_rdata;
  logic [31:0] instr, pc, pc_four, imem_addr, insn_cnt;
  logic        instr_vld, imem_req, misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pc_sel    (pc_sel),
    .i_alu_data  (alu_data),
    .i_dec_rdy   (dec_rdy),
    .o_instr     (instr),
    .o_pc        (pc),
    .o_pc_four   (pc_four),
    .o_instr_vld (instr_vld),
    .o_imem_req  (imem_req),
    .o_imem_addr (imem_addr),
    .i_imem_ack  (imem_ack),
    .i_imem_rdata(imem_rdata),
    .o_misalign  (misalign),
    .o_insn_cnt  (insn_cnt)
  );

  // Reference model: "holding an instruction", "halted", and the address to fetch next.
  bit          m_init = 1'b0;
  bit          m_holding, m_halted, m_mis;
  logic [31:0] m_fetch_addr, m_instr, m_pc, m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_init       = 1'b1;
      m_holding    = 1'b0;
      m_halted     = 1'b0;
      m_mis        = 1'b0;
      m_fetch_addr = RPC;
      m_instr      = 32'h0000_0013;
      m_pc         = RPC;
      m_cnt        = 32'd0;
    end else if (m_init && !m_halted) begin
      if (!m_holding) begin
        if (imem_ack) begin
          m_holding = 1'b1;
          m_instr   = imem_rdata;
          m_pc      = m_fetch_addr;
        end
      end else if (dec_rdy) begin
        m_cnt     = m_cnt + 32'd1;
        m_holding = 1'b0;
        if (pc_sel && alu_data[1]) begin
          m_halted = 1'b1;
          m_mis    = 1'b1;
        end else if (pc_sel) begin
          m_fetch_addr = {alu_data[31:1], 1'b0};
        end else begin
          m_fetch_addr = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      check("m_req", {31'd0, imem_req}, {31'd0, !rst && !m_holding && !m_halted});
      check("m_addr", imem_addr, rst ? RPC : m_fetch_addr);
      check("m_vld", {31'd0, instr_vld}, {31'd0, m_holding});
      check("m_instr", instr, m_instr);
      check("m_pc", pc, m_pc);
      check("m_pc_four", pc_four, m_pc + 32'd4);
      check("m_misalign", {31'd0, misalign}, {31'd0, m_mis});
      check("m_cnt", insn_cnt, m_cnt);
    end
  end

  // One cycle: drive just after the rising edge, return at the falling edge for sampling.
  task automatic apply(input logic r, input logic a, input logic [31:0] d,
                       input logic rdy, input logic s, input logic [31:0] alu);
    @(posedge clk);
    #1;
    rst        = r;
    imem_ack   = a;
    imem_rdata = d;
    dec_rdy    = rdy;
    pc_sel     = s;
    alu_data   = alu;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; dec_rdy = 1'b0; pc_sel = 1'b0; alu_data = '0;

    // Boot, with ack asserted during reset to confirm it is ignored.
    repeat (3) begin
      apply(1, 1, 32'hDEAD_BEEF, 1, 0, 0);
      check("rst_req", {31'd0, imem_req}, 32'd0);
    end
    apply(0, 1, 32'h0050_0093, 0, 0, 0);
    check("boot_req", {31'd0, imem_req}, 32'd1);
    check("boot_addr", imem_addr, 32'h100);
    apply(0, 0, 0, 0, 1, 32'h46);
    check("boot_vld", {31'd0, instr_vld}, 32'd1);
    check("boot_instr", instr, 32'h0050_0093);
    check("boot_pc", pc, 32'h100);
    check("boot_pc_four", pc_four, 32'h104);
    check("boot_req_off", {31'd0, imem_req}, 32'd0);
    apply(0, 0, 0, 1, 0, 0);

    // Wait states, then back-pressure.
    repeat (3) begin
      apply(0, 0, 32'h0BAD_0BAD, 0, 0, 0);
      check("ws_req", {31'd0, imem_req}, 32'd1);
      check("ws_addr", imem_addr, 32'h104);
    end
    check("ws_cnt", insn_cnt, 32'd1);
    apply(0, 1, 32'h00A0_0113, 0, 0, 0);
    repeat (4) apply(0, 0, 0, 0, 1, 32'h46);
    check("bp_instr", instr, 32'h00A0_0113);
    check("bp_pc", pc, 32'h104);
    check("bp_cnt", insn_cnt, 32'd1);
    apply(0, 0, 0, 1, 0, 0);
    apply(0, 1, 32'h0041_0063, 0, 0, 0);
    check("seq_addr", imem_addr, 32'h108);
    check("seq_cnt", insn_cnt, 32'd2);

    // Branch redirect: bit 0 of the target is dropped.
    apply(0, 0, 0, 1, 1, 32'h41);
    check("br_pc", pc, 32'h108);
    apply(0, 1, 32'h0000_1111, 0, 0, 0);
    check("br_addr", imem_addr, 32'h40);
    check("br_mis", {31'd0, misalign}, 32'd0);
    check("br_cnt", insn_cnt, 32'd3);

    // Redirect to the top word, then wrap sequentially to 0.
    apply(0, 0, 0, 1, 1, 32'hFFFF_FFFD);
    apply(0, 1, 32'h0000_2222, 0, 0, 0);
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    apply(0, 0, 0, 1, 0, 0);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_pc_four", pc_four, 32'h0);
    apply(0, 1, 32'h0000_3333, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);

    // Self-loop refetches the same address.
    apply(0, 0, 0, 1, 1, 32'h0);
    check("loop_pc", pc, 32'h0);
    apply(0, 1, 32'h0000_4444, 0, 0, 0);
    check("loop_addr", imem_addr, 32'h0);
    check("loop_cnt", insn_cnt, 32'd6);

    // Misaligned target halts the unit.
    apply(0, 0, 0, 1, 1, 32'h46);
    repeat (5) begin
      apply(0, 1, 32'h0000_5555, 1, 1, 32'h8);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_vld", {31'd0, instr_vld}, 32'd0);
      check("halt_mis", {31'd0, misalign}, 32'd1);
    end
    check("halt_cnt", insn_cnt, 32'd7);
    check("halt_pc_four", pc_four, 32'h4);

    // Reset clears the halt.
    apply(1, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    check("clr_mis", {31'd0, misalign}, 32'd0);
    check("clr_cnt", insn_cnt, 32'd0);
    check("clr_addr", imem_addr, RPC);

    // Reset mid-fetch with a coincident ack.
    apply(1, 1, 32'h0000_6666, 0, 0, 0);
    check("rf_req", {31'd0, imem_req}, 32'd0);
    apply(0, 0, 0, 0, 0, 0);
    check("rf_vld", {31'd0, instr_vld}, 32'd0);
    check("rf_cnt", insn_cnt, 32'd0);
    check("rf_addr", imem_addr, RPC);

    // Reset while an instruction is being consumed: not counted.
    apply(0, 1, 32'h0000_7777, 0, 0, 0);
    apply(1, 0, 0, 1, 0, 0);
    check("rv_req", {31'd0, imem_req}, 32'd0);
    apply(0, 0, 0, 0, 0, 0);
    check("rv_vld", {31'd0, instr_vld}, 32'd0);
    check("rv_cnt", insn_cnt, 32'd0);
    check("rv_instr", instr, 32'h0000_0013);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
